// File: rtl/spi_target.sv
// -----------------------------------------------------------------------------
// spi_target
//    SPI responder for the far end of the ppla SPI link. Emulates a device
//    under test for loopback and regression. CS, SCLK and MOSI are
//    oversampled in the i_clk domain. Each frame captures one MOSI word and
//    shifts out one MISO response word. All four CPOL/CPHA modes are
//    supported, and each direction has its own bit width.
//
// Optional feature macro: SPI_TARGET_ECHO_EN
//    When defined, the i_echo_mode input is added. If i_echo_mode is 1 at
//    frame start, the response word is the previously received word.
//
// Parameters
//    SYNC_STAGES  synchronizer depth on CS/SCLK/MOSI (>= 2)
//    DATA_WIDTH   maximum frame width; the width inputs are clamped to it
//
// Ports
//    i_clk         system clock, all logic on posedge
//    i_reset       synchronous active-high reset
//    i_spi_cs      chip select, active low (asynchronous)
//    i_spi_sclk    serial clock (asynchronous)
//    i_spi_mosi    master-out data (asynchronous)
//    o_spi_miso    master-in data
//    o_miso_oe     MISO drive enable, high while a frame is open
//    i_cpol        SCLK idle level
//    i_cpha        0: sample on leading edge, 1: sample on trailing edge
//    i_mosi_width  bits captured per frame (0 = capture disabled)
//    i_miso_width  bits driven per frame (0 = MISO held 0)
//    i_echo_mode   (SPI_TARGET_ECHO_EN only) respond with last RX word
//    i_tx_data     response word, latched at frame start
//    o_rx_data     last complete MOSI word, right-aligned
//    o_rx_valid    1-cycle pulse when o_rx_data updates
//    o_frame_err   1-cycle pulse when CS is released before the word completes
//    o_busy        high from frame start until the FSM returns to IDLE
// -----------------------------------------------------------------------------
module spi_target #(
   parameter int SYNC_STAGES = 2,
   parameter int DATA_WIDTH  = 32
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_spi_cs,
   input  logic                  i_spi_sclk,
   input  logic                  i_spi_mosi,
   output logic                  o_spi_miso,
   output logic                  o_miso_oe,
   input  logic                  i_cpol,
   input  logic                  i_cpha,
   input  logic [7:0]            i_mosi_width,
   input  logic [7:0]            i_miso_width,
`ifdef SPI_TARGET_ECHO_EN
   input  logic                  i_echo_mode,
`endif
   input  logic [DATA_WIDTH-1:0] i_tx_data,
   output logic [DATA_WIDTH-1:0] o_rx_data,
   output logic                  o_rx_valid,
   output logic                  o_frame_err,
   output logic                  o_busy
);

   localparam int SW = $clog2(SYNC_STAGES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACTIVE,
      S_DONE
   } state_t;

   function automatic logic [7:0] clamp_width(input logic [7:0] w);
      if (int'(w) > DATA_WIDTH) return 8'(DATA_WIDTH);
      return w;
   endfunction

   state_t                  r_state;
   state_t                  w_state_nxt;

   logic [SYNC_STAGES-1:0]  r_cs_sync;
   logic [SYNC_STAGES-1:0]  r_sclk_sync;
   logic [SYNC_STAGES-1:0]  r_mosi_sync;
   logic                    r_sclk_prev;
   logic [SW-1:0]           r_settle;
   logic                    r_armed;

   logic                    r_cpol;
   logic                    r_cpha;
   logic [7:0]              r_mosi_w;
   logic [7:0]              r_miso_w;
   logic [DATA_WIDTH-1:0]   r_rx_shift;
   logic [7:0]              r_rx_cnt;
   logic [DATA_WIDTH-1:0]   r_tx_shift;
   logic [7:0]              r_tx_cnt;

   logic                    r_miso;
   logic                    r_miso_oe;
   logic [DATA_WIDTH-1:0]   r_rx_data;
   logic                    r_rx_valid;
   logic                    r_frame_err;
   logic                    r_busy;

   logic                    w_cs_s;
   logic                    w_sclk_s;
   logic                    w_mosi_s;
   logic                    w_settled;
   logic                    w_sclk_edge;
   logic                    w_lead;
   logic                    w_trail;
   logic                    w_sample;
   logic                    w_shift;
   logic                    w_rx_last;
   logic [DATA_WIDTH-1:0]   w_rx_word;
   logic [7:0]              w_mosi_w_c;
   logic [7:0]              w_miso_w_c;
   logic [DATA_WIDTH-1:0]   w_tx_src;
   logic [DATA_WIDTH-1:0]   w_tx_aligned;
   logic                    w_start;
   logic                    w_capture;
   logic                    w_abort;
   logic                    w_release;

   assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
   assign w_sclk_s  = r_sclk_sync[SYNC_STAGES-1];
   assign w_mosi_s  = r_mosi_sync[SYNC_STAGES-1];
   assign w_settled = (r_settle == SW'(SYNC_STAGES));

   // Edge type is judged against the CPOL latched for the current frame.
   assign w_sclk_edge = (w_sclk_s != r_sclk_prev);
   assign w_lead      = w_sclk_edge && (w_sclk_s != r_cpol);
   assign w_trail     = w_sclk_edge && (w_sclk_s == r_cpol);
   assign w_sample    = r_cpha ? w_trail : w_lead;
   assign w_shift     = r_cpha ? w_lead : w_trail;

   assign w_rx_last = ((r_rx_cnt + 8'd1) == r_mosi_w);
   assign w_rx_word = {r_rx_shift[DATA_WIDTH-2:0], w_mosi_s};

   assign w_mosi_w_c = clamp_width(i_mosi_width);
   assign w_miso_w_c = clamp_width(i_miso_width);

`ifdef SPI_TARGET_ECHO_EN
   assign w_tx_src = i_echo_mode ? r_rx_data : i_tx_data;
`else
   assign w_tx_src = i_tx_data;
`endif

   // Left-align the response so the MSB of the shifter is always the next
   // bit to present, whatever the MISO width.
   assign w_tx_aligned = w_tx_src << (DATA_WIDTH - int'(w_miso_w_c));

   // ---------------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------------
   // NOTE: every clocked process uses non-blocking assignments, so each
   // flop sees the pre-edge values of the others regardless of code order.
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // ---------------------------------------------------------------------
   // FSM next state and event strobes
   // ---------------------------------------------------------------------
   always_comb begin
      // NOTE: defaults first, so no path through the case leaves a signal
      // unassigned; that would infer a latch.
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_capture   = 1'b0;
      w_abort     = 1'b0;
      w_release   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            // A frame opens only once CS has been seen high since reset.
            // This keeps a frame broken by reset from being picked up.
            if (r_armed && !w_cs_s) begin
               w_start     = 1'b1;
               w_state_nxt = (w_mosi_w_c == 8'd0) ? S_DONE : S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            // The final sample wins over a simultaneous CS release.
            if (w_sample && w_rx_last) begin
               w_capture   = 1'b1;
               w_state_nxt = S_DONE;
            end else if (w_cs_s) begin
               w_abort     = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_DONE: begin
            if (w_cs_s) begin
               w_release   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // Synchronizers, arming, and the frame datapath
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cs_sync   <= '1;
         r_sclk_sync <= {SYNC_STAGES{i_cpol}};
         r_mosi_sync <= '0;
         r_sclk_prev <= i_cpol;
         r_settle    <= '0;
         r_armed     <= 1'b0;
         r_cpol      <= i_cpol;
         r_cpha      <= 1'b0;
         r_mosi_w    <= '0;
         r_miso_w    <= '0;
         r_rx_shift  <= '0;
         r_rx_cnt    <= '0;
         r_tx_shift  <= '0;
         r_tx_cnt    <= '0;
         r_miso      <= 1'b0;
         r_miso_oe   <= 1'b0;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_spi_cs};
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_spi_sclk};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
         r_sclk_prev <= w_sclk_s;

         // The chain's reset value reads as "CS high". Arming therefore
         // waits until every stage holds a real sample of the pin.
         if (!w_settled) r_settle <= r_settle + SW'(1);
         if (w_settled && w_cs_s) r_armed <= 1'b1;

         r_rx_valid  <= w_capture;
         r_frame_err <= w_abort;

         if (w_start) begin
            r_cpol     <= i_cpol;
            r_cpha     <= i_cpha;
            r_mosi_w   <= w_mosi_w_c;
            r_miso_w   <= w_miso_w_c;
            r_rx_shift <= '0;
            r_rx_cnt   <= '0;
            r_busy     <= 1'b1;
            r_miso_oe  <= 1'b1;
            // CPHA=0 presents the first bit at frame start. CPHA=1 waits
            // for the first leading edge.
            if (!i_cpha && (w_miso_w_c != 8'd0)) begin
               r_miso     <= w_tx_aligned[DATA_WIDTH-1];
               r_tx_shift <= w_tx_aligned << 1;
               r_tx_cnt   <= 8'd1;
            end else begin
               r_miso     <= 1'b0;
               r_tx_shift <= w_tx_aligned;
               r_tx_cnt   <= 8'd0;
            end
         end else if (w_abort || w_release) begin
            r_busy    <= 1'b0;
            r_miso_oe <= 1'b0;
            r_miso    <= 1'b0;
         end else if (r_state != S_IDLE) begin
            // MISO keeps running in DONE until its own width is used up.
            // Only surplus MOSI bits are dropped.
            if (w_shift) begin
               if (r_tx_cnt < r_miso_w) begin
                  r_miso     <= r_tx_shift[DATA_WIDTH-1];
                  r_tx_shift <= r_tx_shift << 1;
                  r_tx_cnt   <= r_tx_cnt + 8'd1;
               end else begin
                  r_miso <= 1'b0;
               end
            end
            if ((r_state == S_ACTIVE) && w_sample) begin
               r_rx_shift <= w_rx_word;
               r_rx_cnt   <= r_rx_cnt + 8'd1;
            end
            if (w_capture) r_rx_data <= w_rx_word;
         end
      end
   end

   assign o_spi_miso  = r_miso;
   assign o_miso_oe   = r_miso_oe;
   assign o_rx_data   = r_rx_data;
   assign o_rx_valid  = r_rx_valid;
   assign o_frame_err = r_frame_err;
   assign o_busy      = r_busy;

endmodule

// File: tb/tb_spi_target.sv
// -----------------------------------------------------------------------------
// tb_spi_target
//    Directed bench for spi_target. A small SPI master task drives frames.
//    The expected RX words are queued when each frame is sent. A monitor
//    records every o_rx_valid and o_frame_err pulse, and after each frame the
//    queued expectations are compared with what the monitor recorded.
// -----------------------------------------------------------------------------
module tb_spi_target;

   localparam int HALF = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        spi_cs;
   logic        spi_sclk;
   logic        spi_mosi;
   logic        spi_miso;
   logic        miso_oe;
   logic        cpol;
   logic        cpha;
   logic [7:0]  mosi_width;
   logic [7:0]  miso_width;
   logic        echo_mode;
   logic [31:0] tx_data;
   logic [31:0] rx_data;
   logic        rx_valid;
   logic        frame_err;
   logic        busy;

   int          checks = 0;
   int          errors = 0;

   logic [31:0] obs_data [0:63];
   int          n_obs  = 0;
   int          n_ferr = 0;
   int          rd_idx = 0;
   logic [31:0] q_exp [$];

   always #5 clk = ~clk;

   spi_target dut (
`ifdef SPI_TARGET_ECHO_EN
      .i_echo_mode  (echo_mode),
`endif
      .i_clk        (clk),
      .i_reset      (reset),
      .i_spi_cs     (spi_cs),
      .i_spi_sclk   (spi_sclk),
      .i_spi_mosi   (spi_mosi),
      .o_spi_miso   (spi_miso),
      .o_miso_oe    (miso_oe),
      .i_cpol       (cpol),
      .i_cpha       (cpha),
      .i_mosi_width (mosi_width),
      .i_miso_width (miso_width),
      .i_tx_data    (tx_data),
      .o_rx_data    (rx_data),
      .o_rx_valid   (rx_valid),
      .o_frame_err  (frame_err),
      .o_busy       (busy)
   );

   // The monitor samples on the falling edge, away from the DUT's active edge.
   always @(negedge clk) begin
      if (rx_valid) begin
         if (n_obs < 64) obs_data[n_obs] <= rx_data;
         n_obs <= n_obs + 1;
      end
      if (frame_err) n_ferr <= n_ferr + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic half();
      repeat (HALF) @(negedge clk);
   endtask

   task automatic set_mode(input logic p, input logic h);
      half();
      cpol     = p;
      cpha     = h;
      spi_sclk = p;
      half();
   endtask

   // Master side: MSB first. Output rd collects MISO as the master sees it.
   task automatic clock_bits(input int n, input logic [31:0] mosi_word,
                             output logic [31:0] rd);
      rd = '0;
      for (int i = n - 1; i >= 0; i--) begin
         if (!cpha) begin
            spi_mosi = mosi_word[i];
            half();
            spi_sclk = ~cpol;
            rd       = {rd[30:0], spi_miso};
            half();
            spi_sclk = cpol;
         end else begin
            half();
            spi_sclk = ~cpol;
            spi_mosi = mosi_word[i];
            half();
            spi_sclk = cpol;
            rd       = {rd[30:0], spi_miso};
         end
      end
   endtask

   task automatic cs_release();
      half();
      spi_cs = 1'b1;
      half();
      half();
   endtask

   task automatic frame(input int n, input logic [31:0] mosi_word, output logic [31:0] rd);
      spi_cs = 1'b0;
      clock_bits(n, mosi_word, rd);
      cs_release();
   endtask

   // Compare the recorded RX events against the queued expectations.
   task automatic drain(input string tag);
      check({tag, " rx_valid count"}, 32'(n_obs - rd_idx), 32'(q_exp.size()));
      while ((q_exp.size() > 0) && (rd_idx < n_obs)) begin
         check({tag, " rx_data"}, obs_data[rd_idx], q_exp.pop_front());
         rd_idx++;
      end
      q_exp.delete();
      rd_idx = n_obs;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " miso"},      32'(spi_miso),  32'd0);
      check({tag, " miso_oe"},   32'(miso_oe),   32'd0);
      check({tag, " rx_data"},   rx_data,        32'd0);
      check({tag, " rx_valid"},  32'(rx_valid),  32'd0);
      check({tag, " frame_err"}, 32'(frame_err), 32'd0);
      check({tag, " busy"},      32'(busy),      32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      int          ferr0;

      reset      = 1'b1;
      spi_cs     = 1'b1;
      spi_sclk   = 1'b0;
      spi_mosi   = 1'b0;
      cpol       = 1'b0;
      cpha       = 1'b0;
      mosi_width = 8'd32;
      miso_width = 8'd32;
      echo_mode  = 1'b0;
      tx_data    = '0;
      repeat (5) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;
      repeat (6) @(negedge clk);
      check_reset_outputs("post-reset idle");
      ferr0 = n_ferr;

      // Mode 0, full 32-bit frame in both directions.
      tx_data = 32'hA5C3_0F81;
      q_exp.push_back(32'h1234_5678);
      spi_cs = 1'b0;
      repeat (6) @(negedge clk);
      check("m0 busy at start",  32'(busy),     32'd1);
      check("m0 oe at start",    32'(miso_oe),  32'd1);
      check("m0 first miso bit", 32'(spi_miso), 32'd1);
      clock_bits(32, 32'h1234_5678, rd);
      cs_release();
      drain("m0");
      check("m0 master read", rd, 32'hA5C3_0F81);
      check("m0 busy after",  32'(busy),    32'd0);
      check("m0 oe after",    32'(miso_oe), 32'd0);

      // Modes 1..3, 8-bit frames. The upper TX bits must not leak out.
      mosi_width = 8'd8;
      miso_width = 8'd8;
      tx_data    = 32'h1234_56C5;
      for (int m = 1; m <= 3; m++) begin
         set_mode(m[1], m[0]);
         q_exp.push_back(32'h0000_003C);
         frame(8, 32'h3C, rd);
         drain($sformatf("mode%0d", m));
         check($sformatf("mode%0d master read", m), {24'd0, rd[7:0]}, 32'h0000_00C5);
      end
      check("modes no frame_err", 32'(n_ferr - ferr0), 32'd0);

      // CS released after 9 of 16 bits.
      set_mode(1'b0, 1'b0);
      mosi_width = 8'd16;
      miso_width = 8'd16;
      frame(9, 32'h1FF, rd);
      drain("short");
      check("short frame_err pulses", 32'(n_ferr - ferr0), 32'd1);
      check("short rx_data kept",     rx_data,             32'h0000_003C);
      tx_data = 32'hFFFF_1357;
      q_exp.push_back(32'h0000_BEEF);
      frame(16, 32'hBEEF, rd);
      drain("after short");
      check("after short master read", {16'd0, rd[15:0]}, 32'h0000_1357);
      check("after short frame_err",   32'(n_ferr - ferr0), 32'd1);

      // 12 bits clocked into an 8-bit frame. MISO goes to 0 after its 8 bits.
      mosi_width = 8'd8;
      miso_width = 8'd8;
      tx_data    = 32'h0000_00C5;
      q_exp.push_back(32'h0000_00AB);
      spi_cs = 1'b0;
      clock_bits(12, 32'hABC, rd);
      half();
      check("overrun busy before cs high", 32'(busy), 32'd1);
      cs_release();
      drain("overrun");
      check("overrun master read", {20'd0, rd[11:0]}, 32'h0000_0C50);
      check("overrun busy after",  32'(busy),         32'd0);

      // Widths above DATA_WIDTH are clamped to 32.
      mosi_width = 8'd200;
      miso_width = 8'd200;
      tx_data    = 32'h0F0F_A55A;
      q_exp.push_back(32'h8765_4321);
      frame(32, 32'h8765_4321, rd);
      drain("clamp");
      check("clamp master read", rd, 32'h0F0F_A55A);

      // Reset mid-frame with CS held low. Clocks sent before CS goes high
      // again must be ignored.
      mosi_width = 8'd8;
      miso_width = 8'd8;
      tx_data    = 32'h0000_00C5;
      ferr0      = n_ferr;
      spi_cs     = 1'b0;
      clock_bits(5, 32'h15, rd);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check_reset_outputs("mid-frame reset");
      clock_bits(8, 32'hFF, rd);
      check("cs low after reset busy", 32'(busy),    32'd0);
      check("cs low after reset oe",   32'(miso_oe), 32'd0);
      cs_release();
      drain("broken frame");
      check("broken frame_err", 32'(n_ferr - ferr0), 32'd0);
      q_exp.push_back(32'h0000_005A);
      frame(8, 32'h5A, rd);
      drain("post-reset frame");
      check("post-reset master read", {24'd0, rd[7:0]}, 32'h0000_00C5);

`ifdef SPI_TARGET_ECHO_EN
      // Echo: frame 2 returns frame 1's MOSI word.
      mosi_width = 8'd32;
      miso_width = 8'd32;
      tx_data    = 32'h1111_2222;
      echo_mode  = 1'b1;
      q_exp.push_back(32'hDEAD_BEEF);
      frame(32, 32'hDEAD_BEEF, rd);
      q_exp.push_back(32'h0000_0000);
      frame(32, 32'h0, rd);
      drain("echo");
      check("echo master read", rd, 32'hDEAD_BEEF);
      echo_mode = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
